// File: rtl/cpu_io_bridge.sv
// Host strobe synchroniser and one-shot VDP access issuer for the CPU I/O port.
// Define CPU_IO_FILTER_EN to add the FILTER_LEN-sample strobe glitch filter.
module cpu_io_bridge #(
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        csr_n_i,
  input  logic        csw_n_i,
  input  logic [1:0]  mode,
  input  logic [7:0]  cd_i,
  input  logic [7:0]  vdp_dbi,
  output logic        req,
  output logic        wrt,
  output logic [15:0] adr,
  output logic [7:0]  dbo,
  output logic [7:0]  rd_data,
  output logic        rd_oe,
  output logic        conflict
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_CAPT  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  if (FILTER_LEN < 1 || FILTER_LEN > 15) begin : g_len_chk
    $error("FILTER_LEN must be 1..15");
  end

  logic [1:0] rs_q, ws_q;
  logic       r_f, w_f;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rs_q <= 2'b11;
      ws_q <= 2'b11;
    end else begin
      rs_q <= {rs_q[0], csr_n_i};
      ws_q <= {ws_q[0], csw_n_i};
    end
  end

`ifdef CPU_IO_FILTER_EN
  localparam logic [3:0] LIM = 4'(FILTER_LEN - 1);

  logic       rf_q, wf_q;
  logic [3:0] rc_q, wc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_q <= 1'b1;
      wf_q <= 1'b1;
      rc_q <= '0;
      wc_q <= '0;
    end else begin
      if (rs_q[1] == rf_q) begin
        rc_q <= '0;
      end else if (rc_q >= LIM) begin
        rf_q <= rs_q[1];
        rc_q <= '0;
      end else begin
        rc_q <= rc_q + 4'd1;
      end
      if (ws_q[1] == wf_q) begin
        wc_q <= '0;
      end else if (wc_q >= LIM) begin
        wf_q <= ws_q[1];
        wc_q <= '0;
      end else begin
        wc_q <= wc_q + 4'd1;
      end
    end
  end

  assign r_f = rf_q;
  assign w_f = wf_q;
`else
  assign r_f = rs_q[1];
  assign w_f = ws_q[1];
`endif

  logic [1:0] state_q, state_d;
  logic       arm_q, arm_d;
  logic       seen_q;
  logic       rdh_q, rdh_d;
  logic       req_q, req_d;
  logic       wrt_q, wrt_d;
  logic       conf_q, conf_d;
  logic [1:0] mode_q, mode_d;
  logic [7:0] dbo_q, dbo_d;
  logic [7:0] rd_q, rd_d;

  // Until armed (strobes seen released after reset) a low strobe only parks
  // the FSM in HOLD, so an access cut by reset is never re-issued.
  always_comb begin
    state_d = state_q;
    arm_d   = arm_q;
    rdh_d   = rdh_q;
    req_d   = 1'b0;
    wrt_d   = 1'b0;
    conf_d  = 1'b0;
    mode_d  = mode_q;
    dbo_d   = dbo_q;
    rd_d    = rd_q;
    unique case (state_q)
      S_IDLE: begin
        if (!arm_q) begin
          if (!(r_f && w_f)) begin
            state_d = S_HOLD;
          end else if (seen_q && rs_q[0] && ws_q[0]) begin
            arm_d = 1'b1;
          end
        end else if (!r_f && !w_f) begin
          conf_d  = 1'b1;
          state_d = S_HOLD;
        end else if (r_f ^ w_f) begin
          state_d = S_ISSUE;
          req_d   = 1'b1;
          wrt_d   = ~w_f;
          mode_d  = mode;
          if (!w_f) dbo_d = cd_i;
        end
      end
      S_ISSUE: state_d = wrt_q ? S_HOLD : S_CAPT;
      S_CAPT: begin
        rd_d    = vdp_dbi;
        rdh_d   = 1'b1;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (r_f && w_f) begin
          state_d = S_IDLE;
          rdh_d   = 1'b0;
          arm_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      arm_q   <= 1'b0;
      seen_q  <= 1'b0;
      rdh_q   <= 1'b0;
      req_q   <= 1'b0;
      wrt_q   <= 1'b0;
      conf_q  <= 1'b0;
      mode_q  <= '0;
      dbo_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      arm_q   <= arm_d;
      seen_q  <= 1'b1;
      rdh_q   <= rdh_d;
      req_q   <= req_d;
      wrt_q   <= wrt_d;
      conf_q  <= conf_d;
      mode_q  <= mode_d;
      dbo_q   <= dbo_d;
      rd_q    <= rd_d;
    end
  end

  assign req      = req_q;
  assign wrt      = wrt_q;
  assign adr      = {14'b0, mode_q};
  assign dbo      = dbo_q;
  assign rd_data  = rd_q;
  assign conflict = conf_q;
  assign rd_oe    = (state_q == S_HOLD) && rdh_q && !r_f;

endmodule

// File: tb/tb_cpu_io_bridge.sv
// Randomised bench for cpu_io_bridge against an access-level model.
// Filtered strobes are modelled as "value of the latest run of F equal samples".
module tb_cpu_io_bridge;

  localparam int unsigned FLEN = 3;
`ifdef CPU_IO_FILTER_EN
  localparam int F = FLEN;
  localparam int D = 3;
`else
  localparam int F = 1;
  localparam int D = 2;
`endif
  localparam int LAT = D + F;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        csr_n_i, csw_n_i;
  logic [1:0]  mode;
  logic [7:0]  cd_i, vdp_dbi;
  logic        req, wrt, rd_oe, conflict;
  logic [15:0] adr;
  logic [7:0]  dbo, rd_data;

  cpu_io_bridge #(.FILTER_LEN(FLEN)) dut (
    .clk(clk), .reset_n(reset_n),
    .csr_n_i(csr_n_i), .csw_n_i(csw_n_i),
    .mode(mode), .cd_i(cd_i), .vdp_dbi(vdp_dbi),
    .req(req), .wrt(wrt), .adr(adr), .dbo(dbo),
    .rd_data(rd_data), .rd_oe(rd_oe), .conflict(conflict)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  logic rh [0:8191];
  logic wh [0:8191];
  int   k;
  bit   rnd;

  bit   m_busy, m_arm, m_rdh;
  int   m_e0, cap_edge;
  logic e_req, e_wrt, e_conf, e_oe;
  logic [15:0] e_adr;
  logic [7:0]  e_dbo, e_rd;

  int   req_cnt, conf_cnt, oe_cnt, st, first_req;

  function automatic logic fv(input bit wsel, input int kk);
    logic val = 1'b1;
    logic last = 1'b1;
    logic s;
    int run = 0;
    for (int i = 1; i <= kk - D; i++) begin
      s = wsel ? wh[i] : rh[i];
      if (i > 1 && s == last) run++;
      else run = 1;
      last = s;
      if (run >= F) val = s;
    end
    return val;
  endfunction

  task automatic model_reset();
    k = 0; m_busy = 0; m_arm = 0; m_rdh = 0;
    m_e0 = 0; cap_edge = -1;
    e_req = 0; e_wrt = 0; e_conf = 0; e_oe = 0;
    e_adr = '0; e_dbo = '0; e_rd = '0;
  endtask

  task automatic model_edge();
    logic fr, fw;
    fr = fv(1'b0, k);
    fw = fv(1'b1, k);
    e_req = 0; e_wrt = 0; e_conf = 0;
    if (cap_edge == k) begin
      e_rd  = vdp_dbi;
      m_rdh = 1;
    end
    if (m_busy) begin
      if (k >= m_e0 && fr && fw) begin
        m_busy = 0; m_rdh = 0; m_arm = 1;
      end
    end else if (!m_arm) begin
      if (!(fr && fw)) begin
        m_busy = 1; m_e0 = k + 1;
      end else if (k >= 2 && rh[k-1] && wh[k-1]) begin
        m_arm = 1;
      end
    end else if (!fr && !fw) begin
      e_conf = 1; m_busy = 1; m_e0 = k + 1;
    end else if (fr != fw) begin
      e_req  = 1;
      e_wrt  = !fw;
      e_adr  = {14'b0, mode};
      if (!fw) e_dbo = cd_i;
      m_busy = 1;
      if (fw) begin
        m_e0 = k + 3; cap_edge = k + 2;
      end else begin
        m_e0 = k + 2;
      end
    end
    e_oe = m_busy && m_rdh && !fv(1'b0, k + 1);
  endtask

  task automatic tick(input logic r, input logic w);
    csr_n_i = r;
    csw_n_i = w;
    if (rnd) begin
      mode    = 2'($urandom);
      cd_i    = 8'($urandom);
      vdp_dbi = 8'($urandom);
    end
    @(posedge clk);
    k++; st++;
    rh[k] = r;
    wh[k] = w;
    model_edge();
    #1;
    chk("req", {15'b0, req}, {15'b0, e_req});
    chk("wrt", {15'b0, wrt}, {15'b0, e_wrt});
    chk("conflict", {15'b0, conflict}, {15'b0, e_conf});
    chk("adr", adr, e_adr);
    chk("dbo", {8'b0, dbo}, {8'b0, e_dbo});
    chk("rd_data", {8'b0, rd_data}, {8'b0, e_rd});
    chk("rd_oe", {15'b0, rd_oe}, {15'b0, e_oe});
    if (req === 1'b1) begin
      req_cnt++;
      if (first_req < 0) first_req = st;
    end
    if (conflict === 1'b1) conf_cnt++;
    if (rd_oe === 1'b1) oe_cnt++;
    @(negedge clk);
  endtask

  task automatic seg(input logic r, input logic w, input int n);
    for (int i = 0; i < n; i++) tick(r, w);
  endtask

  task automatic clr_cnt();
    req_cnt = 0; conf_cnt = 0; oe_cnt = 0; st = 0; first_req = -1;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #2;
    chk("rst_req", {15'b0, req}, 16'h0);
    chk("rst_wrt", {15'b0, wrt}, 16'h0);
    chk("rst_adr", adr, 16'h0);
    chk("rst_dbo", {8'b0, dbo}, 16'h0);
    chk("rst_rd", {8'b0, rd_data}, 16'h0);
    chk("rst_oe", {15'b0, rd_oe}, 16'h0);
    chk("rst_conf", {15'b0, conflict}, 16'h0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    reset_n = 1'b1;
    csr_n_i = 1'b1; csw_n_i = 1'b1;
    mode = 2'b00; cd_i = 8'h00; vdp_dbi = 8'h00;
    rnd = 0;
    model_reset();
    clr_cnt();
    @(negedge clk);
    pulse_reset();
    seg(1, 1, 8);

    mode = 2'b01; cd_i = 8'hA5; vdp_dbi = 8'h00;
    clr_cnt();
    seg(1, 0, 20);
    chk("wr_req_cnt", 16'(req_cnt), 16'd1);
    chk("wr_req_tick", 16'(first_req), 16'(LAT));
    chk("wr_adr", adr, 16'h0001);
    chk("wr_dbo", {8'b0, dbo}, 16'h00A5);
    seg(1, 1, 10);

    mode = 2'b10; cd_i = 8'h5A; vdp_dbi = 8'h3C;
    clr_cnt();
    seg(0, 1, 20);
    seg(1, 1, 10);
    chk("rd_req_cnt", 16'(req_cnt), 16'd1);
    chk("rd_data_3c", {8'b0, rd_data}, 16'h003C);
    chk("rd_dbo_kept", {8'b0, dbo}, 16'h00A5);
    chk("rd_oe_seen", {15'b0, (oe_cnt > 0)}, 16'd1);

    clr_cnt();
    seg(1, 0, (F > 1) ? F - 1 : 1);
    seg(1, 1, 12);
    chk("glitch_req", 16'(req_cnt), (F > 1) ? 16'd0 : 16'd1);
    chk("glitch_conf", 16'(conf_cnt), 16'd0);

    clr_cnt();
    seg(0, 0, 10);
    seg(1, 1, 10);
    chk("conf_cnt", 16'(conf_cnt), 16'd1);
    chk("conf_req", 16'(req_cnt), 16'd0);
    clr_cnt();
    seg(1, 0, 12);
    seg(1, 1, 10);
    chk("post_conf_req", 16'(req_cnt), 16'd1);

    clr_cnt();
    seg(1, 0, 12);
    pulse_reset();
    clr_cnt();
    seg(1, 0, 20);
    chk("rst_hold_req", 16'(req_cnt), 16'd0);
    chk("rst_hold_conf", 16'(conf_cnt), 16'd0);
    seg(1, 1, 10);
    clr_cnt();
    seg(1, 0, 20);
    seg(1, 1, 10);
    chk("rst_rearm_req", 16'(req_cnt), 16'd1);

    rnd = 1;
    for (int n = 0; n < 120; n++) begin
      int kind;
      kind = int'($urandom_range(5, 0));
      unique case (kind)
        0: seg(1, 0, int'($urandom_range(12, 1)));
        1: seg(0, 1, int'($urandom_range(12, 1)));
        2: seg(0, 0, int'($urandom_range(6, 1)));
        3: begin
          seg(0, 1, int'($urandom_range(6, 1)));
          seg(0, 0, int'($urandom_range(4, 1)));
        end
        default: seg(1, 1, int'($urandom_range(10, 1)));
      endcase
    end
    seg(1, 1, 10);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
